// File: rtl/timer_pkg.sv
// timer_pkg: register map, divider tables and bit positions shared by the
// programmable timer channel and its prescalers.
package timer_pkg;

  // Channel register offsets from BASE_ADDR.
  localparam logic [2:0] REG_CTRL_L   = 3'd0;
  localparam logic [2:0] REG_CTRL_H   = 3'd1;
  localparam logic [2:0] REG_PRESET_L = 3'd2;
  localparam logic [2:0] REG_PRESET_H = 3'd3;
  localparam logic [2:0] REG_PIVOT_L  = 3'd4;
  localparam logic [2:0] REG_PIVOT_H  = 3'd5;
  localparam logic [2:0] REG_COUNT_L  = 3'd6;
  localparam logic [2:0] REG_COUNT_H  = 3'd7;

  // CTRL_L / CTRL_H bit positions.
  localparam int CTRL_LOAD_BIT   = 1;
  localparam int CTRL_RUN_BIT    = 2;
  localparam int CTRL_MODE16_BIT = 7;
  localparam logic [7:0] CTRL_LOAD_MASK = 8'h02;

  // SCALE register: one 4-bit field per half, lo in [3:0], hi in [7:4].
  localparam int SCALE_FIELD_W = 4;
  localparam int SCALE_SEL_W   = 3;
  localparam int SCALE_EN_OFS  = 3;

  // Divider tables stored as (divider - 1): the largest osc1 divider is 4096,
  // which only fits 12 bits as a mask. Entry 0 is the rightmost element.
  localparam logic [7:0][11:0] OSC1_DIV_MASK = {
    12'd4095, 12'd1023, 12'd255, 12'd127, 12'd63, 12'd31, 12'd7, 12'd1
  };
  localparam logic [7:0][11:0] OSC2_DIV_MASK = {
    12'd127, 12'd63, 12'd31, 12'd15, 12'd7, 12'd3, 12'd1, 12'd0
  };

  // Divider mask for the selected oscillator source and divider select.
  function automatic logic [11:0] div_mask(input logic src_osc2, input logic [2:0] sel);
    return src_osc2 ? OSC2_DIV_MASK[sel] : OSC1_DIV_MASK[sel];
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: oscillator source mux, 12-bit prescale counter and the
// divided half-tick output for one half of a timer channel.
module timer_prescaler
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_ce,
  input  logic       osc1_tick,
  input  logic       osc2_tick,
  input  logic       src_osc2,
  input  logic       enable,
  input  logic [2:0] div_sel,
  output logic       tick
);

  logic [11:0] pcnt_reg;
  logic [11:0] mask;
  logic        src_tick;

  assign src_tick = src_osc2 ? osc2_tick : osc1_tick;
  assign mask     = div_mask(src_osc2, div_sel);

  // The half ticks on the source tick that completes a full divider period;
  // with mask 0 (divide by 1) every source tick qualifies.
  assign tick = clk_ce && enable && src_tick && ((pcnt_reg & mask) == mask);

  // Prescale counter: held at 0 while disabled, counts selected source ticks.
  always_ff @(posedge clk) begin
    if (clk_ce) begin
      if (reset || !enable) begin
        pcnt_reg <= '0;
      end else if (src_tick) begin
        pcnt_reg <= pcnt_reg + 12'd1;
      end
    end
  end

endmodule

// File: rtl/prog_timer.sv
// prog_timer: one programmable timer channel with lo/hi 8-bit down-counters
// that can cascade into a single 16-bit counter.
// Optional feature: define PROG_TIMER_PIVOT_EN to make PIVOT_L/H writable and
// drive tout from a registered count <= pivot compare; otherwise tout is 0.
module prog_timer
  import timer_pkg::*;
#(
  parameter logic [23:0] SCALE_ADDR = 24'h2018,
  parameter logic [23:0] OSC_ADDR   = 24'h2019,
  parameter logic [23:0] BASE_ADDR  = 24'h2030
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_ce,
  input  logic        bus_write,
  input  logic [23:0] bus_address_in,
  input  logic [7:0]  bus_data_in,
  input  logic        osc1_tick,
  input  logic        osc2_tick,
  output logic [7:0]  bus_data_out,
  output logic [1:0]  irq_underflow,
  output logic        tout
);

  logic [7:0]  scale_reg;
  logic [1:0]  osc_reg;
  logic [7:0]  ctrl_l_reg;
  logic [7:0]  ctrl_h_reg;
  logic [7:0]  preset_l_reg;
  logic [7:0]  preset_h_reg;
  logic [7:0]  count_lo_reg;
  logic [7:0]  count_hi_reg;
  logic [7:0]  count_lo_next;
  logic [7:0]  count_hi_next;
  logic [1:0]  irq_reg;
  logic [1:0]  irq_next;
  logic [1:0]  half_tick;

  logic [23:0] chan_offset;
  logic        chan_hit;
  logic        scale_hit;
  logic        osc_hit;
  logic [2:0]  reg_idx;
  logic        wr_ctrl_l;
  logic        wr_ctrl_h;
  logic        lo_load;
  logic        hi_load;
  logic        mode16;
  logic        run_lo;
  logic        run_hi;
  logic [15:0] count16;
  logic [15:0] preset16;
  logic [7:0]  rd_data;

`ifdef PROG_TIMER_PIVOT_EN
  logic [7:0]  pivot_l_reg;
  logic [7:0]  pivot_h_reg;
  logic        tout_reg;
  assign tout = tout_reg;
`else
  assign tout = 1'b0;
`endif

  // Address decode: the channel window is 8 bytes starting at BASE_ADDR.
  assign chan_offset = bus_address_in - BASE_ADDR;
  assign chan_hit    = (chan_offset < 24'd8);
  assign reg_idx     = chan_offset[2:0];
  assign scale_hit   = (bus_address_in == SCALE_ADDR);
  assign osc_hit     = (bus_address_in == OSC_ADDR);

  assign mode16   = ctrl_l_reg[CTRL_MODE16_BIT];
  assign run_lo   = ctrl_l_reg[CTRL_RUN_BIT];
  assign run_hi   = ctrl_h_reg[CTRL_RUN_BIT];
  assign count16  = {count_hi_reg, count_lo_reg};
  assign preset16 = {preset_h_reg, preset_l_reg};

  assign wr_ctrl_l = bus_write && chan_hit && (reg_idx == REG_CTRL_L);
  assign wr_ctrl_h = bus_write && chan_hit && (reg_idx == REG_CTRL_H);

  // A CTRL_L load that also selects 16-bit mode loads both halves, so a single
  // write can set up, load and start the cascaded counter. CTRL_H loads only
  // act while the channel is in 8-bit mode.
  assign lo_load = wr_ctrl_l && bus_data_in[CTRL_LOAD_BIT];
  assign hi_load = (lo_load && bus_data_in[CTRL_MODE16_BIT]) ||
                   (wr_ctrl_h && bus_data_in[CTRL_LOAD_BIT] && !mode16);

  assign irq_underflow = irq_reg;
  assign bus_data_out  = rd_data;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pre
      timer_prescaler u_pre (
        .clk       (clk),
        .reset     (reset),
        .clk_ce    (clk_ce),
        .osc1_tick (osc1_tick),
        .osc2_tick (osc2_tick),
        .src_osc2  (osc_reg[gi]),
        .enable    (scale_reg[gi*SCALE_FIELD_W + SCALE_EN_OFS]),
        .div_sel   (scale_reg[gi*SCALE_FIELD_W +: SCALE_SEL_W]),
        .tick      (half_tick[gi])
      );
    end
  endgenerate

  // Next count and underflow pulse; a preset load always beats a coincident tick.
  always_comb begin
    count_lo_next = count_lo_reg;
    count_hi_next = count_hi_reg;
    irq_next      = 2'b00;
    if (mode16) begin
      if (lo_load || hi_load) begin
        if (lo_load) count_lo_next = preset_l_reg;
        if (hi_load) count_hi_next = preset_h_reg;
      end else if (half_tick[0] && run_lo) begin
        if (count16 == 16'd0) begin
          {count_hi_next, count_lo_next} = preset16;
          irq_next[1] = 1'b1;
        end else begin
          {count_hi_next, count_lo_next} = count16 - 16'd1;
        end
      end
    end else begin
      if (lo_load) begin
        count_lo_next = preset_l_reg;
      end else if (half_tick[0] && run_lo) begin
        if (count_lo_reg == 8'd0) begin
          count_lo_next = preset_l_reg;
          irq_next[0]   = 1'b1;
        end else begin
          count_lo_next = count_lo_reg - 8'd1;
        end
      end
      if (hi_load) begin
        count_hi_next = preset_h_reg;
      end else if (half_tick[1] && run_hi) begin
        if (count_hi_reg == 8'd0) begin
          count_hi_next = preset_h_reg;
          irq_next[1]   = 1'b1;
        end else begin
          count_hi_next = count_hi_reg - 8'd1;
        end
      end
    end
  end

  // Bus-writable configuration registers; the load strobe bit is never stored.
  always_ff @(posedge clk) begin
    if (clk_ce) begin
      if (reset) begin
        scale_reg    <= '0;
        osc_reg      <= '0;
        ctrl_l_reg   <= '0;
        ctrl_h_reg   <= '0;
        preset_l_reg <= '0;
        preset_h_reg <= '0;
`ifdef PROG_TIMER_PIVOT_EN
        pivot_l_reg  <= '0;
        pivot_h_reg  <= '0;
`endif
      end else if (bus_write) begin
        if (scale_hit) scale_reg <= bus_data_in;
        if (osc_hit)   osc_reg   <= bus_data_in[1:0];
        if (chan_hit) begin
          case (reg_idx)
            REG_CTRL_L:   ctrl_l_reg   <= bus_data_in & ~CTRL_LOAD_MASK;
            REG_CTRL_H:   ctrl_h_reg   <= bus_data_in & ~CTRL_LOAD_MASK;
            REG_PRESET_L: preset_l_reg <= bus_data_in;
            REG_PRESET_H: preset_h_reg <= bus_data_in;
`ifdef PROG_TIMER_PIVOT_EN
            REG_PIVOT_L:  pivot_l_reg  <= bus_data_in;
            REG_PIVOT_H:  pivot_h_reg  <= bus_data_in;
`endif
            default: ;
          endcase
        end
      end
    end
  end

  // Counters, underflow pulse and pivot output advance once per clk_ce; the
  // pulse register is rewritten every clk_ce so it lasts exactly one of them.
  always_ff @(posedge clk) begin
    if (clk_ce) begin
      if (reset) begin
        count_lo_reg <= '0;
        count_hi_reg <= '0;
        irq_reg      <= '0;
`ifdef PROG_TIMER_PIVOT_EN
        tout_reg     <= 1'b0;
`endif
      end else begin
        count_lo_reg <= count_lo_next;
        count_hi_reg <= count_hi_next;
        irq_reg      <= irq_next;
`ifdef PROG_TIMER_PIVOT_EN
        tout_reg     <= mode16 ? (count16 <= {pivot_h_reg, pivot_l_reg})
                               : (count_lo_reg <= pivot_l_reg);
`endif
      end
    end
  end

  // Combinational read-back; unmatched addresses return 0 for OR-combining.
  always_comb begin
    rd_data = 8'h00;
    if (scale_hit) begin
      rd_data = scale_reg;
    end else if (osc_hit) begin
      rd_data = {6'b000000, osc_reg};
    end else if (chan_hit) begin
      case (reg_idx)
        REG_CTRL_L:   rd_data = ctrl_l_reg;
        REG_CTRL_H:   rd_data = ctrl_h_reg;
        REG_PRESET_L: rd_data = preset_l_reg;
        REG_PRESET_H: rd_data = preset_h_reg;
`ifdef PROG_TIMER_PIVOT_EN
        REG_PIVOT_L:  rd_data = pivot_l_reg;
        REG_PIVOT_H:  rd_data = pivot_h_reg;
`endif
        REG_COUNT_L:  rd_data = count_lo_reg;
        REG_COUNT_H:  rd_data = count_hi_reg;
        default:      rd_data = 8'h00;
      endcase
    end
  end

endmodule
